// File: rtl/gfx_stream_arbiter.sv
// Round-robin, packet-atomic arbiter merging PORTS valid/ready streams into one
// registered output stream (1-cycle latency, full throughput).
module gfx_stream_arbiter #(
  parameter int WIDTH = 32,
  parameter int PORTS = 4,
  parameter int SRC_W = $clog2(PORTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS*WIDTH-1:0] in,
  input  logic [PORTS-1:0]       in_last,
  input  logic [PORTS-1:0]       in_valid,
  output logic [PORTS-1:0]       in_ready,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out,
  output logic                   out_last,
  output logic [SRC_W-1:0]       out_src
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_next;
  logic [SRC_W-1:0] owner, owner_next;
  logic [SRC_W-1:0] prio, prio_next;
  logic [SRC_W-1:0] sel;
  logic             sel_ok;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;
  logic             load;
  logic             accept;

  // (base + k) mod PORTS without relying on power-of-2 wrap
  function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= PORTS) s = s - PORTS;
    return SRC_W'(s);
  endfunction

  always_comb begin
    sel    = owner;
    sel_ok = 1'b0;
    if (state == LOCKED) begin
      sel_ok = in_valid[owner];
    end else begin
      // Scan downward so the lowest offset from prio wins.
      for (int k = PORTS - 1; k >= 0; k--) begin
        if (in_valid[wrap_add(prio, k)]) begin
          sel    = wrap_add(prio, k);
          sel_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (SRC_W'(i) == sel) sel_data = in[i*WIDTH +: WIDTH];
    end
    sel_last = in_last[sel];
  end

  assign load   = !out_valid || out_ready;
  assign accept = load && sel_ok && !rst;

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      in_ready[i] = accept && (SRC_W'(i) == sel);
    end
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
    prio_next  = prio;
    if (accept) begin
      if (sel_last) begin
        state_next = IDLE;
        prio_next  = (sel == SRC_W'(PORTS - 1)) ? '0 : sel + SRC_W'(1);
      end else begin
        state_next = LOCKED;
        owner_next = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      prio      <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      prio  <= prio_next;
      if (accept) begin
        out_valid <= 1'b1;
        out       <= sel_data;
        out_last  <= sel_last;
        out_src   <= sel;
      end else if (load) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gfx_stream_arbiter.sv
// Randomized bench for gfx_stream_arbiter: packet sources per port, a cycle
// reference model of grant/priority rules, plus a directed 3-port wrap check.
module tb_gfx_stream_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] din;
  logic [3:0]   dlast, dvalid, drdy;
  logic         ordy, ov, olast;
  logic [31:0]  dout;
  logic [1:0]   osrc;

  logic         brst;
  logic [95:0]  bin;
  logic [2:0]   blast, bvalid, bready;
  logic         bordy, bov, blast_o;
  logic [31:0]  bout;
  logic [1:0]   bsrc;

  always #5 clk = ~clk;

  gfx_stream_arbiter #(.WIDTH(32), .PORTS(4)) dut (
    .clk(clk), .rst(rst), .in(din), .in_last(dlast), .in_valid(dvalid), .in_ready(drdy),
    .out_ready(ordy), .out_valid(ov), .out(dout), .out_last(olast), .out_src(osrc)
  );

  gfx_stream_arbiter #(.WIDTH(32), .PORTS(3)) dut3 (
    .clk(clk), .rst(brst), .in(bin), .in_last(blast), .in_valid(bvalid), .in_ready(bready),
    .out_ready(bordy), .out_valid(bov), .out(bout), .out_last(blast_o), .out_src(bsrc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  // Reference model state
  bit          m_locked;
  int          m_owner, m_prio;
  bit          m_ov, m_last;
  logic [31:0] m_out;
  int          m_src;
  int          m_sel;
  bit          m_ok, m_load;
  logic [3:0]  exp_rdy;

  // Packet sources
  bit          s_valid [4];
  bit          s_last  [4];
  logic [31:0] s_data  [4];
  int          s_rem   [4];

  initial begin
    rst = 1'b1; din = '0; dlast = '0; dvalid = '0; ordy = 1'b1;
    brst = 1'b1; bin = {32'hC2, 32'hC1, 32'hC0}; blast = 3'b111; bvalid = '0; bordy = 1'b1;
    m_locked = 0; m_owner = 0; m_prio = 0; m_ov = 0; m_last = 0; m_out = '0; m_src = 0;
    for (int p = 0; p < 4; p++) begin
      s_valid[p] = 0; s_last[p] = 0; s_data[p] = '0; s_rem[p] = 0;
    end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst = (cyc < 3) ? 1'b1 : ($urandom_range(0, 399) == 0);
      if ((cyc % 300) >= 100 && (cyc % 300) < 105) ordy = 1'b0;
      else ordy = ($urandom_range(0, 7) != 0);
      for (int p = 0; p < 4; p++) begin
        if (!s_valid[p]) begin
          if (s_rem[p] == 0) begin
            if (cyc < 4 || $urandom_range(0, 3) == 0) begin
              s_rem[p]   = $urandom_range(1, 4);
              s_valid[p] = 1;
            end
          end else if ($urandom_range(0, 3) != 0) begin
            s_valid[p] = 1;
          end
          if (s_valid[p]) begin
            s_data[p] = $urandom;
            s_last[p] = (s_rem[p] == 1);
          end
        end
        dvalid[p]        = s_valid[p];
        dlast[p]         = s_last[p];
        din[p*32 +: 32]  = s_data[p];
      end
      #1;

      m_load = !m_ov || ordy;
      m_ok   = 0;
      m_sel  = 0;
      if (m_locked) begin
        m_sel = m_owner;
        m_ok  = s_valid[m_owner];
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (!m_ok && s_valid[(m_prio + k) % 4]) begin
            m_sel = (m_prio + k) % 4;
            m_ok  = 1;
          end
        end
      end
      exp_rdy = (!rst && m_load && m_ok) ? (4'b0001 << m_sel) : 4'b0000;

      if (cyc == 3) check("rst_release_ready", drdy, 4'b0001);
      check("in_ready", drdy, exp_rdy);
      check("out_valid", ov, m_ov);
      if (m_ov) begin
        check("out", dout, m_out);
        check("out_last", olast, m_last);
        check("out_src", osrc, m_src);
      end

      if (rst) begin
        m_locked = 0; m_owner = 0; m_prio = 0; m_ov = 0; m_last = 0; m_out = '0; m_src = 0;
      end else if (exp_rdy != 0) begin
        m_ov   = 1;
        m_out  = s_data[m_sel];
        m_last = s_last[m_sel];
        m_src  = m_sel;
        if (s_last[m_sel]) begin
          m_locked = 0;
          m_prio   = (m_sel + 1) % 4;
        end else begin
          m_locked = 1;
          m_owner  = m_sel;
        end
        s_rem[m_sel]   = s_rem[m_sel] - 1;
        s_valid[m_sel] = 0;
      end else if (m_load) begin
        m_ov = 0;
      end
    end

    // 3-port instance: priority wrap for non-power-of-2 PORTS
    @(negedge clk); brst = 1'b1; bvalid = 3'b000;
    @(negedge clk); brst = 1'b0; bvalid = 3'b010; #1;
    check("p3_grant1", bready, 3'b010);
    @(negedge clk); bvalid = 3'b001; #1;
    check("p3_prio2_grant0", bready, 3'b001);
    check("p3_src1", bsrc, 2'd1);
    check("p3_data1", bout, 32'hC1);
    @(negedge clk); bvalid = 3'b111; #1;
    check("p3_prio_wrap1", bready, 3'b010);
    check("p3_src0", bsrc, 2'd0);
    @(negedge clk); bvalid = 3'b100; #1;
    check("p3_grant2", bready, 3'b100);
    @(negedge clk); bvalid = 3'b111; #1;
    check("p3_prio_wrap0", bready, 3'b001);
    check("p3_src2", bsrc, 2'd2);
    @(negedge clk); bvalid = 3'b000;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
